// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester burst round-robin arbiter steering a 2:1 mux into a registered valid/ready output stage
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic prio, can_take, acc, acc_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((req0_valid | req1_valid) ? BURST : IDLE)
                               : ((acc && acc_last) ? IDLE : BURST);
  always_comb begin
    busy       = (state == BURST);
    can_take   = !out_valid | out_ready;
    req0_ready = busy & !sel & can_take;
    req1_ready = busy & sel & can_take;
    acc        = sel ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
    acc_last   = sel ? req1_last : req0_last;
  end
  // sel only moves at arbitration, so the mux is stable for the whole burst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prio      <= 1'b0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && (req0_valid | req1_valid))
        sel <= (req0_valid & req1_valid) ? prio : req1_valid;
      if (acc) begin
        out_data  <= sel ? req1_data : req0_data;
        out_last  <= acc_last;
        out_valid <= 1'b1;
        if (acc_last) prio <= ~sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule
